// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - round-robin scheduler sharing one 16-point FFT core
// between two frame requesters, with a bounded wait on the core's done.
module fft_frame_scheduler #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [WIDTH*16-1:0] req0_real,
  input  logic [WIDTH*16-1:0] req0_imag,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [WIDTH*16-1:0] req1_real,
  input  logic [WIDTH*16-1:0] req1_imag,
  output logic                fft_start,
  output logic [WIDTH*16-1:0] fft_in_real,
  output logic [WIDTH*16-1:0] fft_in_imag,
  input  logic                fft_done,
  input  logic [WIDTH*16-1:0] fft_out_real,
  input  logic [WIDTH*16-1:0] fft_out_imag,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_id,
  output logic                res_error,
  output logic [WIDTH*16-1:0] res_real,
  output logic [WIDTH*16-1:0] res_imag,
  output logic                busy
);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t     state, state_next;
  logic       last_grant;
  logic       owner;
  logic [7:0] timer;
  logic       grant0, grant1;
  logic       take0, take1;
  logic       expired;

  // Under contention the requester that did not win last time goes first.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;
  assign take0      = req0_ready && req0_valid;
  assign take1      = req1_ready && req1_valid;
  assign expired    = (timer == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fft_start  = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (take0 || take1) state_next = START;
      end
      START: begin
        fft_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (fft_done || expired) state_next = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      timer       <= 8'd0;
      fft_in_real <= '0;
      fft_in_imag <= '0;
      res_id      <= 1'b0;
      res_error   <= 1'b0;
      res_real    <= '0;
      res_imag    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take0 || take1) begin
            fft_in_real <= take1 ? req1_real : req0_real;
            fft_in_imag <= take1 ? req1_imag : req0_imag;
            owner       <= take1;
            last_grant  <= take1;
          end
        end
        START: timer <= 8'd0;
        WAIT: begin
          // A done on the expiry cycle is checked first, so it still returns data.
          if (fft_done) begin
            res_real  <= fft_out_real;
            res_imag  <= fft_out_imag;
            res_error <= 1'b0;
            res_id    <= owner;
          end else if (expired) begin
            res_real  <= '0;
            res_imag  <= '0;
            res_error <= 1'b1;
            res_id    <= owner;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb/tb_fft_frame_scheduler.sv - self-checking bench for fft_frame_scheduler with a
// behavioural FFT core stand-in and a transaction-level scheduler model.
module tb_fft_frame_scheduler;
  localparam int W  = 16;
  localparam int BW = W * 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [BW-1:0] req0_real = '0, req0_imag = '0, req1_real = '0, req1_imag = '0;
  logic          fft_start, fft_done;
  logic [BW-1:0] fft_in_real, fft_in_imag;
  logic [BW-1:0] fft_out_real = '0, fft_out_imag = '0;
  logic          res_valid, res_id, res_error, busy;
  logic          res_ready = 1'b0;
  logic [BW-1:0] res_real, res_imag;

  logic core_done = 1'b0, spur_done = 1'b0, armed = 1'b0;
  int   core_lat = -1, cnt = 0;
  int   checks = 0, errors = 0;

  assign fft_done = core_done | spur_done;

  always #5 clk = ~clk;

  fft_frame_scheduler #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_real(req0_real), .req0_imag(req0_imag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_real(req1_real), .req1_imag(req1_imag),
    .fft_start(fft_start), .fft_in_real(fft_in_real), .fft_in_imag(fft_in_imag),
    .fft_done(fft_done), .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_error(res_error),
    .res_real(res_real), .res_imag(res_imag), .busy(busy)
  );

  // Core stand-in: every bin's real part is the sum of the real inputs, imag is input+bin.
  function automatic logic [BW-1:0] model_re(input logic [BW-1:0] x);
    logic [BW-1:0] r;
    logic [W-1:0]  s;
    s = '0;
    for (int k = 0; k < 16; k++) s = s + x[k*W +: W];
    for (int k = 0; k < 16; k++) r[k*W +: W] = s;
    return r;
  endfunction

  function automatic logic [BW-1:0] model_im(input logic [BW-1:0] x);
    logic [BW-1:0] r;
    for (int k = 0; k < 16; k++) r[k*W +: W] = x[k*W +: W] + W'(k);
    return r;
  endfunction

  // done lands in WAIT cycle index core_lat (0 = first WAIT cycle); negative never finishes.
  always @(negedge clk) begin
    if (fft_start) begin
      fft_out_real = model_re(fft_in_real);
      fft_out_imag = model_im(fft_in_imag);
      armed     = (core_lat >= 0);
      cnt       = core_lat;
      core_done = 1'b0;
    end else if (armed && cnt == 0) begin
      core_done = 1'b1;
      armed     = 1'b0;
    end else begin
      core_done = 1'b0;
      if (armed) cnt--;
    end
  end

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic rand_frame(output logic [BW-1:0] re, output logic [BW-1:0] im);
    for (int k = 0; k < 16; k++) begin
      re[k*W +: W] = W'($urandom);
      im[k*W +: W] = W'($urandom);
    end
  endtask

  // Called #1 into the START cycle; exp_k counts cycles from the accept cycle to RESP.
  task automatic await_res(input string tag, input int exp_k, input logic exp_id, input logic exp_err,
                           input logic [BW-1:0] er, input logic [BW-1:0] ei);
    int k;
    k = 1;
    while (res_valid !== 1'b1 && k < 40) begin
      @(negedge clk); #1;
      k++;
      chk1({tag, "_no_restart"}, fft_start, 1'b0);
    end
    chki({tag, "_latency"}, k, exp_k);
    chk1({tag, "_res_id"}, res_id, exp_id);
    chk1({tag, "_res_error"}, res_error, exp_err);
    chk({tag, "_res_real"}, res_real, er);
    chk({tag, "_res_imag"}, res_imag, ei);
  endtask

  typedef struct {
    logic v0;
    logic v1;
    int   lat;
    logic impulse;
    logic exp_id;
    logic exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input string tag);
    logic [BW-1:0] r0r, r0i, r1r, r1i, er, ei;
    int lat_eff;
    rand_frame(r0r, r0i);
    rand_frame(r1r, r1i);
    if (v.impulse) begin
      r0r = '0;
      r0r[W-1:0] = 16'h4000;
      r0i = '0;
    end
    @(negedge clk);
    req0_real = r0r; req0_imag = r0i; req1_real = r1r; req1_imag = r1i;
    req0_valid = v.v0; req1_valid = v.v1;
    core_lat = v.lat; res_ready = 1'b1;
    #1;
    chk1({tag, "_ready0"}, req0_ready, !v.exp_id);
    chk1({tag, "_ready1"}, req1_ready, v.exp_id);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk1({tag, "_start"}, fft_start, 1'b1);
    chk({tag, "_fft_in_real"}, fft_in_real, v.exp_id ? r1r : r0r);
    chk({tag, "_fft_in_imag"}, fft_in_imag, v.exp_id ? r1i : r0i);
    lat_eff = (v.lat < 0 || v.lat > TO) ? TO : v.lat;
    er = v.exp_err ? '0 : model_re(v.exp_id ? r1r : r0r);
    ei = v.exp_err ? '0 : model_im(v.exp_id ? r1i : r0i);
    await_res(tag, 3 + lat_eff, v.exp_id, v.exp_err, er, ei);
    @(negedge clk); #1;
    chk1({tag, "_idle_busy"}, busy, 1'b0);
    chk1({tag, "_idle_res_valid"}, res_valid, 1'b0);
  endtask

  logic [BW-1:0] a_r, a_i, b_r, b_i, e_r, e_i;
  logic [BW-1:0] f0r, f0i, f1r, f1i, m_re, m_im;
  logic          m_last, m_id, m_err, e0, e1;
  int            m_phase, m_acc, m_resp_at, lat;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1,  4, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1,  0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1,  2, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1,  5, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0,  4, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1,  8, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b1};

    #1 rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_ready1", req1_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_start", fft_start, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk1("rst_res_id", res_id, 1'b0);
    chk1("rst_res_error", res_error, 1'b0);
    chk("rst_fft_in_real", fft_in_real, '0);
    chk("rst_res_real", res_real, '0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Backpressure: result held while requester 1 waits and done glitches arrive.
    rand_frame(a_r, a_i);
    rand_frame(b_r, b_i);
    @(negedge clk);
    req0_real = a_r; req0_imag = a_i; req0_valid = 1'b1;
    req1_valid = 1'b0; core_lat = 2; res_ready = 1'b0;
    #1 chk1("bp_ready0", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_real = b_r; req1_imag = b_i; req1_valid = 1'b1;
    #1;
    e_r = model_re(a_r);
    e_i = model_im(a_i);
    await_res("bp", 5, 1'b0, 1'b0, e_r, e_i);
    repeat (20) begin
      @(negedge clk);
      spur_done = 1'($urandom_range(0, 1));
      #1;
      chk1("bp_hold_valid", res_valid, 1'b1);
      chk("bp_hold_real", res_real, e_r);
      chk("bp_hold_imag", res_imag, e_i);
      chk1("bp_hold_id", res_id, 1'b0);
      chk1("bp_ready1_low", req1_ready, 1'b0);
      chk1("bp_no_start", fft_start, 1'b0);
    end
    @(negedge clk);
    spur_done = 1'b0; res_ready = 1'b1; core_lat = 0;
    @(negedge clk); #1;
    chk1("bp_ready1_after", req1_ready, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1 await_res("bp_next", 3, 1'b1, 1'b0, model_re(b_r), model_im(b_i));
    @(negedge clk);

    // Asynchronous reset while WAITing on a core that never finishes.
    rand_frame(a_r, a_i);
    @(negedge clk);
    req0_real = a_r; req0_imag = a_i; req0_valid = 1'b1; core_lat = -1;
    #1 chk1("ar_ready0", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk1("ar_busy", busy, 1'b0);
    chk1("ar_start", fft_start, 1'b0);
    chk1("ar_res_valid", res_valid, 1'b0);
    chk1("ar_ready0", req0_ready, 1'b0);
    chk("ar_fft_in_real", fft_in_real, '0);
    @(negedge clk);
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (15) begin
      @(negedge clk); #1;
      chk1("ar_quiet_res_valid", res_valid, 1'b0);
      chk1("ar_quiet_busy", busy, 1'b0);
    end
    rand_frame(a_r, a_i);
    rand_frame(b_r, b_i);
    @(negedge clk);
    req0_real = a_r; req0_imag = a_i; req1_real = b_r; req1_imag = b_i;
    req0_valid = 1'b1; req1_valid = 1'b1; core_lat = 3;
    #1;
    chk1("ar_post_ready0", req0_ready, 1'b1);
    chk1("ar_post_ready1", req1_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1 await_res("ar_post", 6, 1'b0, 1'b0, model_re(a_r), model_im(a_i));
    @(negedge clk);

    // Randomized traffic against a timestamp-level model of the scheduler.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_phase = 0; m_last = 1'b1; m_acc = -10; m_resp_at = 0;
    m_id = 1'b0; m_err = 1'b0; m_re = '0; m_im = '0;
    rand_frame(f0r, f0i);
    rand_frame(f1r, f1i);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (m_phase == 1 && c == m_resp_at) m_phase = 2;
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      res_ready  = ($urandom_range(0, 3) != 0);
      req0_real = f0r; req0_imag = f0i; req1_real = f1r; req1_imag = f1i;
      #1;
      e0 = (m_phase == 0) && req0_valid && (!req1_valid || m_last);
      e1 = (m_phase == 0) && req1_valid && (!req0_valid || !m_last);
      chk1("rnd_ready0", req0_ready, e0);
      chk1("rnd_ready1", req1_ready, e1);
      chk1("rnd_busy", busy, m_phase != 0);
      chk1("rnd_res_valid", res_valid, m_phase == 2);
      chk1("rnd_start", fft_start, m_phase == 1 && c == m_acc + 1);
      if (m_phase == 2) begin
        chk1("rnd_res_id", res_id, m_id);
        chk1("rnd_res_error", res_error, m_err);
        chk("rnd_res_real", res_real, m_re);
        chk("rnd_res_imag", res_imag, m_im);
      end
      if (e0 || e1) begin
        lat       = $urandom_range(0, 10);
        core_lat  = lat;
        m_acc     = c;
        m_id      = e1;
        m_last    = e1;
        m_err     = (lat > TO);
        m_resp_at = c + 3 + ((lat > TO) ? TO : lat);
        m_re      = m_err ? '0 : model_re(e1 ? f1r : f0r);
        m_im      = m_err ? '0 : model_im(e1 ? f1i : f0i);
        m_phase   = 1;
        if (e1) rand_frame(f1r, f1i);
        else rand_frame(f0r, f0i);
      end else if (m_phase == 2 && res_ready) begin
        m_phase = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_frame_scheduler.md
# fft_frame_scheduler

Front-end scheduler that shares one 16-point radix-2² FFT core (`fft_radix2_2_top`) between two frame requesters.
- Accepts a complete 16-sample complex frame from either requester over valid/ready, arbitrating round-robin.
- Registers the frame onto the core's inputs, pulses `start`, waits for `done`, and returns the spectrum to the owning requester over a valid/ready result port.
- Aborts with an error response if the core does not finish within a bounded number of cycles.

## Interface
- `WIDTH`, 16: bits per real/imag sample component. Buses are WIDTH*16, with sample k at bits [(k+1)*WIDTH-1 -: WIDTH].
- `TIMEOUT`, 32: maximum WAIT cycles allowed for `fft_done` before an error response; legal range 1..255.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req0_valid`, in, 1: requester 0 has a frame.
- `req0_ready`, out, 1: requester 0 frame accepted this cycle when high together with `req0_valid`.
- `req0_real` / `req0_imag`, in, WIDTH*16: requester 0 frame.
- `req1_valid`, `req1_ready`, `req1_real`, `req1_imag`: same as the requester 0 ports, for requester 1.
- `fft_start`, out, 1: one-cycle start pulse to the core.
- `fft_in_real` / `fft_in_imag`, out, WIDTH*16: registered frame driven to the core's `data_in_*`.
- `fft_done`, in, 1: core completion. Sampled only in WAIT.
- `fft_out_real` / `fft_out_imag`, in, WIDTH*16: core result.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: consumer accepts the result.
- `res_id`, out, 1: requester that owns the result.
- `res_error`, out, 1: 1 means timeout; data is zero.
- `res_real` / `res_imag`, out, WIDTH*16: registered result.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
**State machine:** IDLE, START, WAIT, RESP.

**IDLE**
- Grant is combinational. If exactly one request is valid, that requester is granted. If both are valid, grant the requester that is not `last_grant`.
- `reqN_ready` = (state==IDLE) && grant==N. At most one ready is high at a time, and no ready is high outside IDLE.
- Handshake: latch the frame into `fft_in_*`, set `owner` to N and `last_grant` to N, then go to START.

**START**
- `fft_start`=1 for this cycle only.
- Clear the timer. Next state is WAIT.

**WAIT**
- If `fft_done`=1: capture `fft_out_*` into `res_*`, set `res_error`=0, `res_id`=`owner`, go to RESP.
- Otherwise increment the timer.
- If the timer reaches TIMEOUT without `fft_done`: set `res_*`=0, `res_error`=1, `res_id`=`owner`, go to RESP.
- `fft_done` on the same edge as expiry: done wins and no error is flagged.

**RESP**
- `res_valid`=1. Hold all `res_*` stable until `res_ready`=1, then go to IDLE.

**Other rules**
- `fft_done` in IDLE, START or RESP is ignored.
- The core must deassert `done` before the cycle after `fft_start`. A stale high done seen in the first WAIT cycle completes the job; this is the core's contract.
- `fft_in_*` holds the last accepted frame until the next acceptance.
- Timer width is 8 bits.

## Timing
**Reset values:** state IDLE; `last_grant`=1, so requester 0 wins first contention; all `fft_in_*`, `res_*`, `owner`, timer = 0; `fft_start`=0, `res_valid`=0, `busy`=0. Ready ports are 0 while `rst_n`=0.

**Latency:**
- Accept at edge T. `fft_start` high in cycle T+1. WAIT begins at cycle T+2.
- `fft_done` sampled high at cycle D gives `res_valid` from cycle D+1.
- Timeout: `res_valid` in cycle T+2+TIMEOUT+1.
- After result handshake at cycle R, IDLE in R+1, and a new frame can be accepted in cycle R+1. Minimum frame spacing is therefore 4 cycles plus core latency.

**Backpressure:**
- `res_ready` low holds RESP indefinitely. No new frame is accepted meanwhile; both readies stay 0.
- Requesters may drop `valid` before acceptance without effect.

**Reset mid-operation:** outputs clear asynchronously. An in-flight frame is dropped and no response is issued. `fft_start` drops immediately.

## Test plan
1. **Single frame from requester 0, impulse.** `req0_real` sample0=0x4000, rest 0, `req0_valid`=1. Expect `req0_ready` high in IDLE and `fft_start` one cycle after accept. A core model asserts `fft_done` after 4 cycles. Expect `res_valid` the cycle after done, `res_id`=0, `res_error`=0, and `res_real` equal to the model output (all 16 bins 0x4000 for an ideal model).
2. **Contention fairness.** Both requesters hold valid for 4 frames with `res_ready`=1. Expect grants in order 0,1,0,1 and `res_id` sequence 0,1,0,1. Never both readies high in one cycle.
3. **Timeout.** TIMEOUT=8, the core model never asserts done. Expect `res_valid` exactly 9 cycles after the first WAIT cycle, with `res_error`=1, `res_real`/`res_imag` all zero and `res_id`=owner. The next frame is accepted after `res_ready`.
4. **Done at expiry edge.** TIMEOUT=8, done arrives in WAIT cycle 8. Expect `res_error`=0 and the captured data.
5. **Backpressure and ignored done.** `res_ready`=0 for 20 cycles while `req1_valid`=1 and spurious `fft_done` pulses occur. Expect `res_*` stable, `req1_ready`=0, and no second `fft_start`. After `res_ready`=1, `req1_ready` asserts the following cycle.
6. **Async reset in WAIT.** Assert `rst_n`=0 mid-cycle during WAIT. Expect `busy`, `fft_start` and `res_valid` at 0 immediately, and no response after release. The first post-reset contention grants requester 0.
